// File: rtl/spi_adc_resp.sv
// ============================================================================
// spi_adc_resp : SPI slave emulating an 8-channel 12-bit ADC (one-frame
// pipelined readback). Optional framing checks: SPI_ADC_RESP_FRMERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_adc_resp #(
   parameter int NUM_CH      = 8,
   parameter int DW          = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 SCLK,
   input  logic                 MOSI,
   output logic                 MISO,
   input  logic [NUM_CH*DW-1:0] chan_data,
   output logic                 cmd_vld,
   output logic [15:0]          last_cmd,
   output logic                 frm_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
   logic                   ss_prev_q, sclk_prev_q;
   logic                   w_ss_s, w_sclk_s, w_mosi_s;
   logic                   w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [15:0] tx_q, tx_d, rx_q, rx_d, last_q, last_d;
   logic        miso_q, miso_d, vld_q, vld_d;
   logic [15:0] w_word;
`ifdef SPI_ADC_RESP_FRMERR_EN
   logic        err_q, err_d, ovr_q, ovr_d;
`endif

   // SS_n flops reset low so a slave select still held low after rst never yields a fall
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync_q   <= '0;
         ss_prev_q   <= 1'b0;
         sclk_sync_q <= '1;
         sclk_prev_q <= 1'b1;
         mosi_sync_q <= '0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
         ss_prev_q   <= w_ss_s;
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         sclk_prev_q <= w_sclk_s;
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      end
   end

   assign w_ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign w_ss_fall   = ss_prev_q & ~w_ss_s;
   assign w_ss_rise   = ~ss_prev_q & w_ss_s;
   assign w_sclk_rise = ~sclk_prev_q & w_sclk_s;
   assign w_sclk_fall = sclk_prev_q & ~w_sclk_s;

   // Unpopulated pointer values read back as zero
   always_comb begin
      w_word = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (ptr_q == 3'(n)) w_word[DW-1:0] = chan_data[n*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         last_q  <= '0;
         miso_q  <= 1'b0;
         vld_q   <= 1'b0;
`ifdef SPI_ADC_RESP_FRMERR_EN
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         last_q  <= last_d;
         miso_q  <= miso_d;
         vld_q   <= vld_d;
`ifdef SPI_ADC_RESP_FRMERR_EN
         err_q   <= err_d;
         ovr_q   <= ovr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      last_d  = last_q;
      miso_d  = miso_q;
      vld_d   = 1'b0;
`ifdef SPI_ADC_RESP_FRMERR_EN
      err_d   = 1'b0;
      ovr_d   = ovr_q;
`endif
      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (w_ss_fall) begin
               tx_d    = w_word;
               miso_d  = w_word[15];
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef SPI_ADC_RESP_FRMERR_EN
               ovr_d   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            if (w_ss_rise) begin
               state_d = IDLE;
               miso_d  = 1'b0;
`ifdef SPI_ADC_RESP_FRMERR_EN
               err_d   = 1'b1;
`endif
            end else if (w_sclk_rise) begin
               rx_d  = {rx_q[14:0], w_mosi_s};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd15) state_d = DONE;
            end else if (w_sclk_fall && (cnt_q != 5'd0)) begin
               // First fall precedes any rise: MSB is already on MISO
               tx_d   = {tx_q[14:0], 1'b0};
               miso_d = tx_q[14];
            end
         end
         DONE: begin
            if (w_ss_rise) begin
               state_d = IDLE;
               miso_d  = 1'b0;
`ifdef SPI_ADC_RESP_FRMERR_EN
               if (ovr_q) begin
                  err_d = 1'b1;
               end else begin
                  last_d = rx_q;
                  ptr_d  = rx_q[13:11];
                  vld_d  = 1'b1;
               end
`else
               last_d = rx_q;
               ptr_d  = rx_q[13:11];
               vld_d  = 1'b1;
`endif
            end
`ifdef SPI_ADC_RESP_FRMERR_EN
            else if (w_sclk_rise) begin
               ovr_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign MISO     = miso_q;
   assign cmd_vld  = vld_q;
   assign last_cmd = last_q;
`ifdef SPI_ADC_RESP_FRMERR_EN
   assign frm_err  = err_q;
`else
   assign frm_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_adc_resp.sv
// ============================================================================
// tb_spi_adc_resp : directed SPI frames against spi_adc_resp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_adc_resp;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n, SCLK, MOSI;
   logic        MISO;
   logic [95:0] chan_data;
   logic        cmd_vld;
   logic [15:0] last_cmd;
   logic        frm_err;

   int checks = 0;
   int failures = 0;
   int vld_cnt = 0;
   int err_cnt = 0;

   spi_adc_resp dut (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .chan_data (chan_data),
      .cmd_vld   (cmd_vld),
      .last_cmd  (last_cmd),
      .frm_err   (frm_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cmd_vld === 1'b1) vld_cnt++;
      if (frm_err === 1'b1) err_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Master frame: MOSI changes on SCLK fall, MISO sampled just before SCLK rise
   task automatic xfer(input logic [15:0] cmd, input int nclk, input int chg_bit,
                       input int rst_bit, output logic [15:0] rd);
      rd = '0;
      SS_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         if (i == rst_bit) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
         if (i == chg_bit) chan_data[11:0] = 12'h222;
         SCLK = 1'b0;
         MOSI = (i < 16) ? cmd[15-i] : 1'b0;
         repeat (HALF) @(negedge clk);
         if (i < 16) rd = {rd[14:0], MISO};
         SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      SS_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      logic [15:0] rd;
      int v0, e0;
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      chan_data = '0;
      chan_data[0*12 +: 12] = 12'hA5C;
      chan_data[1*12 +: 12] = 12'h456;
      chan_data[4*12 +: 12] = 12'h123;
      chan_data[5*12 +: 12] = 12'hFFF;
      chan_data[7*12 +: 12] = 12'h7E7;
      repeat (5) @(negedge clk);
      check("rst_miso", {15'd0, MISO}, 16'd0);
      check("rst_vld", {15'd0, cmd_vld}, 16'd0);
      check("rst_last", last_cmd, 16'h0000);
      check("rst_err", {15'd0, frm_err}, 16'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // Frame 1: first frame after reset returns channel 0
      v0 = vld_cnt; e0 = err_cnt;
      xfer(16'h2000, 16, -1, -1, rd);
      check("f1_rd", rd, 16'h0A5C);
      check("f1_vld", 16'(vld_cnt - v0), 16'd1);
      check("f1_err", 16'(err_cnt - e0), 16'd0);
      check("f1_last", last_cmd, 16'h2000);
      check("f1_miso_idle", {15'd0, MISO}, 16'd0);

      v0 = vld_cnt;
      xfer(16'h2800, 16, -1, -1, rd);
      check("f2_rd", rd, 16'h0123);
      check("f2_vld", 16'(vld_cnt - v0), 16'd1);
      check("f2_last", last_cmd, 16'h2800);

      xfer(16'h0000, 16, -1, -1, rd);
      check("f3_rd", rd, 16'h0FFF);
      check("f3_last", last_cmd, 16'h0000);

      // Short frame is discarded
      v0 = vld_cnt; e0 = err_cnt;
      xfer(16'h2800, 9, -1, -1, rd);
      check("abort_vld", 16'(vld_cnt - v0), 16'd0);
`ifdef SPI_ADC_RESP_FRMERR_EN
      check("abort_err", 16'(err_cnt - e0), 16'd1);
`else
      check("abort_err", 16'(err_cnt - e0), 16'd0);
`endif
      check("abort_last", last_cmd, 16'h0000);

      xfer(16'h3800, 16, -1, -1, rd);
      check("f5_rd", rd, 16'h0A5C);
      check("f5_last", last_cmd, 16'h3800);

      // Over-length frame (18 clocks)
      v0 = vld_cnt; e0 = err_cnt;
      xfer(16'h0800, 18, -1, -1, rd);
      check("long_rd", rd, 16'h07E7);
`ifdef SPI_ADC_RESP_FRMERR_EN
      check("long_vld", 16'(vld_cnt - v0), 16'd0);
      check("long_err", 16'(err_cnt - e0), 16'd1);
      check("long_last", last_cmd, 16'h3800);
`else
      check("long_vld", 16'(vld_cnt - v0), 16'd1);
      check("long_err", 16'(err_cnt - e0), 16'd0);
      check("long_last", last_cmd, 16'h0800);
`endif

      xfer(16'h0000, 16, -1, -1, rd);
`ifdef SPI_ADC_RESP_FRMERR_EN
      check("f7_rd", rd, 16'h07E7);
`else
      check("f7_rd", rd, 16'h0456);
`endif

      // Channel data changed mid-frame does not disturb the snapshot
      chan_data[11:0] = 12'h111;
      xfer(16'h0000, 16, 4, -1, rd);
      check("snap_rd", rd, 16'h0111);

      // Reset mid-frame; SS_n stays low through 16 clocks
      v0 = vld_cnt;
      xfer(16'h2000, 16, -1, 7, rd);
      check("rstmid_rd_lo", {7'd0, rd[8:0]}, 16'h0000);
      check("rstmid_vld", 16'(vld_cnt - v0), 16'd0);
      check("rstmid_miso", {15'd0, MISO}, 16'd0);
      check("rstmid_last", last_cmd, 16'h0000);

      v0 = vld_cnt;
      xfer(16'h2800, 16, -1, -1, rd);
      check("post_rd", rd, 16'h0222);
      check("post_vld", 16'(vld_cnt - v0), 16'd1);
      check("post_last", last_cmd, 16'h2800);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
